// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes and datapath mux selects.
package mc_ctrl_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   typedef struct packed {
      logic ld;
      logic st;
      logic r;
      logic i;
      logic br;
      logic jal;
   } op_class_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave).
interface mc_control_fsm_if;

   logic [6:0] op;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] imm_src;
   logic       reg_write;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  op, zero, mem_ready,
      output pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
             instr_done, illegal
   );

   modport slave (
      output op, zero, mem_ready,
      input  pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
             instr_done, illegal
   );

endinterface

// File: rtl/mc_op_class.sv
// Opcode classifier: one-hot instruction class, illegal flag and immediate format.
module mc_op_class
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output op_class_t  cls,
   output logic       illegal,
   output logic [1:0] imm_src
);

   always_comb begin
      cls     = '0;
      imm_src = IMM_I;
      case (op)
         OP_LW:  cls.ld = 1'b1;
         OP_SW:  begin cls.st = 1'b1;  imm_src = IMM_S; end
         OP_R:   cls.r = 1'b1;
         OP_I:   cls.i = 1'b1;
         OP_BEQ: begin cls.br = 1'b1;  imm_src = IMM_B; end
         OP_JAL: begin cls.jal = 1'b1; imm_src = IMM_J; end
         default: cls = '0;
      endcase
      illegal = ~|cls;
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I-subset control FSM (lw, sw, R, I, beq, jal).
// Define MC_MEM_WAIT_EN to stall FETCH/MEMREAD/MEMWRITE on mem_ready.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic          clk,
   input  logic          reset,
   mc_control_fsm_if.master bus
);

   logic [STATE_W-1:0] state_q;
   state_t             state;
   state_t             state_next;
   op_class_t          cls;
   logic               illegal_op;
   logic               pc_update;
   logic               branch;
   logic               mem_ok;

   mc_op_class u_op_class (
      .op      (bus.op),
      .cls     (cls),
      .illegal (illegal_op),
      .imm_src (bus.imm_src)
   );

`ifdef MC_MEM_WAIT_EN
   assign mem_ok = bus.mem_ready;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = bus.mem_ready;
   assign mem_ok           = 1'b1;
`endif

   assign state = state_t'(state_q);

   always_ff @(posedge clk) begin
      if (reset) state_q <= STATE_W'(S_FETCH);
      else       state_q <= STATE_W'(state_next);
   end

   always_comb begin
      state_next     = state;
      pc_update      = 1'b0;
      branch         = 1'b0;
      bus.adr_src    = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.result_src = RES_ALUOUT;
      bus.alu_src_a  = SRCA_PC;
      bus.alu_src_b  = SRCB_RS2;
      bus.alu_op     = ALUOP_ADD;
      bus.reg_write  = 1'b0;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;

      case (state)
         S_FETCH: begin
            bus.ir_write   = mem_ok;
            bus.alu_src_b  = SRCB_FOUR;
            bus.result_src = RES_ALU;
            pc_update      = mem_ok;
            if (mem_ok) state_next = S_DECODE;
         end
         S_DECODE: begin
            bus.alu_src_a = SRCA_OLDPC;
            bus.alu_src_b = SRCB_IMM;
            if (illegal_op)          state_next = S_TRAP;
            else if (cls.ld | cls.st) state_next = S_MEMADR;
            else if (cls.r)           state_next = S_EXECR;
            else if (cls.i)           state_next = S_EXECI;
            else if (cls.br)          state_next = S_BEQ;
            else                      state_next = S_JAL;
         end
         S_MEMADR: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_src_b = SRCB_IMM;
            // op must stay a load/store here; anything else is an IR corruption.
            if (cls.ld)      state_next = S_MEMREAD;
            else if (cls.st) state_next = S_MEMWRITE;
            else             state_next = S_TRAP;
         end
         S_MEMREAD: begin
            bus.adr_src = 1'b1;
            if (mem_ok) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            bus.result_src = RES_RDATA;
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
            state_next     = S_FETCH;
         end
         S_MEMWRITE: begin
            bus.adr_src    = 1'b1;
            bus.mem_write  = 1'b1;
            bus.instr_done = mem_ok;
            if (mem_ok) state_next = S_FETCH;
         end
         S_EXECR: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_op    = ALUOP_FUNCT;
            state_next    = S_ALUWB;
         end
         S_EXECI: begin
            bus.alu_src_a = SRCA_RS1;
            bus.alu_src_b = SRCB_IMM;
            bus.alu_op    = ALUOP_FUNCT;
            state_next    = S_ALUWB;
         end
         S_ALUWB: begin
            bus.reg_write  = 1'b1;
            bus.instr_done = 1'b1;
            state_next     = S_FETCH;
         end
         S_BEQ: begin
            bus.alu_src_a  = SRCA_RS1;
            bus.alu_op     = ALUOP_SUB;
            branch         = 1'b1;
            bus.instr_done = 1'b1;
            state_next     = S_FETCH;
         end
         S_JAL: begin
            bus.alu_src_a = SRCA_OLDPC;
            bus.alu_src_b = SRCB_FOUR;
            pc_update     = 1'b1;
            state_next    = S_ALUWB;
         end
         S_TRAP: begin
            bus.illegal = 1'b1;
         end
         default: state_next = S_TRAP;
      endcase

      bus.pc_write = pc_update | (branch & bus.zero);

      // Reset shows FETCH selects but suppresses every write strobe.
      if (reset) begin
         state_next     = S_FETCH;
         bus.pc_write   = 1'b0;
         bus.adr_src    = 1'b0;
         bus.mem_write  = 1'b0;
         bus.ir_write   = 1'b0;
         bus.result_src = RES_ALU;
         bus.alu_src_a  = SRCA_PC;
         bus.alu_src_b  = SRCB_FOUR;
         bus.alu_op     = ALUOP_ADD;
         bus.reg_write  = 1'b0;
         bus.instr_done = 1'b0;
         bus.illegal    = 1'b0;
      end
   end

endmodule
